pool_stage: RTL and testbench

- Pooling stage directly upstream of the activation stage: takes the post-normalization vector stream (MAT_MUL_SIZE lanes of DWIDTH) and reduces every W consecutive vectors element-wise (max, or optionally average).
- Emits one vector per window with the same in_data_available / validity_mask interface the activation stage consumes.
- Supports runtime bypass and partial-window flush at end of stream.

---
 rtl/pool_pkg.sv | 34 +++
 rtl/pool_lane.sv | 81 ++++++++
 rtl/pool_stage.sv | 122 ++++++++++++
 tb/tb_pool_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types for the pooling stage: window encodings, FSM states, accumulator sizing.
// Build option: POOL_AVG_EN enables average pooling alongside max pooling.
package pool_pkg;

    typedef enum logic [1:0] {
        WIN_1   = 2'b00,
        WIN_2   = 2'b01,
        WIN_4   = 2'b10,
        WIN_RSV = 2'b11
    } win_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pool_state_e;

    // Two guard bits hold the sum of four signed lanes without overflow.
    localparam int unsigned ACC_GUARD = 2;

    function automatic int unsigned acc_width(input int unsigned dw);
        return dw + ACC_GUARD;
    endfunction

    // Reserved encoding behaves as the widest window.
    function automatic logic [1:0] win_log2(input logic [1:0] enc);
        case (enc)
            WIN_1:   return 2'd0;
            WIN_2:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One-lane reducer: load/max (or add) accumulator, final shift and mask gate.
// Build option: POOL_AVG_EN widens the accumulator and adds the sum/shift path.
module pool_lane
    import pool_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic              i_first,
    input  logic              i_last,
    input  logic              i_flush,
    input  logic              i_avg,
    input  logic [1:0]        i_shift,
    input  logic              i_mask,
    input  logic              i_flush_mask,
    input  logic [DWIDTH-1:0] i_data,
    output logic [DWIDTH-1:0] o_win_c,
    output logic [DWIDTH-1:0] o_flush_c
);

`ifdef POOL_AVG_EN
    localparam int unsigned AW = acc_width(DWIDTH);
`else
    localparam int unsigned AW = DWIDTH;
`endif

    logic signed [DWIDTH-1:0] w_in_s;
    logic signed [AW-1:0]     w_in_ext;
    logic signed [AW-1:0]     w_next;
    logic signed [AW-1:0]     w_win_res;
    logic signed [AW-1:0]     w_flush_res;
    logic signed [AW-1:0]     r_acc;

    assign w_in_s   = i_data;
    assign w_in_ext = AW'(w_in_s);

    // First vector of a window loads; later ones reduce into the accumulator.
    always_comb begin
        w_next = w_in_ext;
        if (!i_first) begin
`ifdef POOL_AVG_EN
            if (i_avg) begin
                w_next = r_acc + w_in_ext;
            end else if (r_acc > w_in_ext) begin
                w_next = r_acc;
            end
`else
            if (r_acc > w_in_ext) begin
                w_next = r_acc;
            end
`endif
        end
    end

`ifdef POOL_AVG_EN
    // Partial windows still divide by the full window size.
    assign w_win_res   = i_avg ? (w_next >>> i_shift) : w_next;
    assign w_flush_res = i_avg ? (r_acc >>> i_shift) : r_acc;
`else
    logic w_unused;
    assign w_unused    = ^{i_avg, i_shift};
    assign w_win_res   = w_next;
    assign w_flush_res = r_acc;
`endif

    assign o_win_c   = i_mask       ? DWIDTH'(w_win_res)   : '0;
    assign o_flush_c = i_flush_mask ? DWIDTH'(w_flush_res) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
        end else if (i_flush) begin
            r_acc <= '0;
        end else if (i_valid) begin
            r_acc <= i_last ? '0 : w_next;
        end
    end

endmodule

// File: rtl/pool_stage.sv
// Pooling stage: reduces every W consecutive vectors lane-wise, with bypass and end-of-stream flush.
// Build option: POOL_AVG_EN honours pool_select (average pooling); otherwise max only.
module pool_stage
    import pool_pkg::*;
#(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned MAT_MUL_SIZE = 4,
    parameter int unsigned MASK_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           enable_pool,
    input  logic [1:0]                     pool_window_size,
    input  logic                           pool_select,
    input  logic                           in_data_available,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]          validity_mask,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_data_available,
    output logic                           done_pool
);

    localparam int unsigned VW = MAT_MUL_SIZE * DWIDTH;

    pool_state_e           r_state;
    logic [1:0]            r_cnt;
    logic [1:0]            r_log2w;
    logic                  r_avg;
    logic [MASK_WIDTH-1:0] r_mask;

    logic          w_start;
    logic [1:0]    w_log2w;
    logic          w_avg;
    logic [1:0]    w_cnt;
    logic [1:0]    w_last_idx;
    logic          w_first;
    logic          w_last;
    logic          w_flush;
    logic [VW-1:0] w_win_vec;
    logic [VW-1:0] w_flush_vec;

    // The first vector of a stream uses the live config; the rest use the latched copy.
    assign w_start    = in_data_available && (r_state != ACCUM);
    assign w_log2w    = w_start ? (enable_pool ? win_log2(pool_window_size) : 2'd0) : r_log2w;
    assign w_avg      = w_start ? pool_select : r_avg;
    assign w_cnt      = w_start ? 2'd0 : r_cnt;
    assign w_last_idx = 2'((3'd1 << w_log2w) - 3'd1);
    assign w_first    = (w_cnt == 2'd0);
    assign w_last     = (w_cnt == w_last_idx);
    assign w_flush    = (r_state == ACCUM) && !in_data_available && (r_cnt != 2'd0);

    for (genvar g = 0; g < MAT_MUL_SIZE; g++) begin : g_lane
        pool_lane #(
            .DWIDTH (DWIDTH)
        ) u_lane (
            .clk          (clk),
            .resetn       (resetn),
            .i_valid      (in_data_available),
            .i_first      (w_first),
            .i_last       (w_last),
            .i_flush      (w_flush),
            .i_avg        (w_avg),
            .i_shift      (w_log2w),
            .i_mask       (validity_mask[g]),
            .i_flush_mask (r_mask[g]),
            .i_data       (inp_data[g*DWIDTH +: DWIDTH]),
            .o_win_c      (w_win_vec[g*DWIDTH +: DWIDTH]),
            .o_flush_c    (w_flush_vec[g*DWIDTH +: DWIDTH])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state            <= IDLE;
            r_cnt              <= 2'd0;
            r_log2w            <= 2'd0;
            r_avg              <= 1'b0;
            r_mask             <= '0;
            out_data           <= '0;
            out_data_available <= 1'b0;
            done_pool          <= 1'b0;
        end else begin
            out_data_available <= 1'b0;

            if (in_data_available) begin
                r_mask <= validity_mask;
                if (w_last) begin
                    out_data           <= w_win_vec;
                    out_data_available <= 1'b1;
                    r_cnt              <= 2'd0;
                end else begin
                    r_cnt <= w_cnt + 2'd1;
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (in_data_available) begin
                        r_state   <= ACCUM;
                        r_log2w   <= w_log2w;
                        r_avg     <= w_avg;
                        done_pool <= 1'b0;
                    end
                end
                ACCUM: begin
                    // Falling edge of in_data_available ends the stream.
                    if (!in_data_available) begin
                        if (w_flush) begin
                            out_data           <= w_flush_vec;
                            out_data_available <= 1'b1;
                        end
                        r_cnt     <= 2'd0;
                        r_state   <= DONE;
                        done_pool <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_stage.sv
// Directed bench for pool_stage: bypass, max windows, flush, masking, reset, optional average.
module tb_pool_stage;

    logic        clk;
    logic        resetn;
    logic        enable_pool;
    logic [1:0]  pool_window_size;
    logic        pool_select;
    logic        in_data_available;
    logic [31:0] inp_data;
    logic [3:0]  validity_mask;
    logic [31:0] out_data;
    logic        out_data_available;
    logic        done_pool;

    int n_tests = 0;
    int n_fail  = 0;

    pool_stage #(
        .DWIDTH       (8),
        .MAT_MUL_SIZE (4),
        .MASK_WIDTH   (4)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .enable_pool        (enable_pool),
        .pool_window_size   (pool_window_size),
        .pool_select        (pool_select),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_pool          (done_pool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one vector at a falling edge; return at the next falling edge.
    task automatic send(input logic [31:0] d, input logic [3:0] m);
        in_data_available = 1'b1;
        inp_data          = d;
        validity_mask     = m;
        @(negedge clk);
    endtask

    task automatic idle();
        in_data_available = 1'b0;
        inp_data          = '0;
        validity_mask     = 4'hF;
        @(negedge clk);
    endtask

    initial begin
        resetn            = 1'b0;
        enable_pool       = 1'b0;
        pool_window_size  = 2'b00;
        pool_select       = 1'b0;
        in_data_available = 1'b0;
        inp_data          = '0;
        validity_mask     = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_data", out_data, 32'h0);
        check("rst_avail", 32'(out_data_available), 32'd0);
        check("rst_done", 32'(done_pool), 32'd0);
        resetn = 1'b1;
        idle();

        // Bypass: single vector, then done two cycles after the input
        send(32'h04030201, 4'hF);
        check("byp_data", out_data, 32'h04030201);
        check("byp_avail", 32'(out_data_available), 32'd1);
        check("byp_done_low", 32'(done_pool), 32'd0);
        idle();
        check("byp_avail_off", 32'(out_data_available), 32'd0);
        check("byp_done", 32'(done_pool), 32'd1);

        // Bypass masking and back-to-back vectors; done clears on restart
        send(32'hAABBCCDD, 4'b0110);
        check("byp_mask", out_data, 32'h00BBCC00);
        check("byp_done_clr", 32'(done_pool), 32'd0);
        send(32'h11223344, 4'hF);
        check("byp_b2b_data", out_data, 32'h11223344);
        check("byp_b2b_avail", 32'(out_data_available), 32'd1);
        idle();

        // Max W2: {5,-3,7,-128} then {2,4,-1,127} -> {5,4,7,127}; then a second window
        enable_pool      = 1'b1;
        pool_window_size = 2'b01;
        send(32'h8007FD05, 4'hF);
        check("w2_first_quiet", 32'(out_data_available), 32'd0);
        send(32'h7FFF0402, 4'hF);
        check("w2_avail", 32'(out_data_available), 32'd1);
        check("w2_data", out_data, 32'h7F070405);
        send(32'h01010101, 4'hF);
        check("w2_b2b_quiet", 32'(out_data_available), 32'd0);
        send(32'h0003FEFF, 4'hF);
        check("w2_b2b_data", out_data, 32'h01030101);
        idle();
        check("w2_end_no_pulse", 32'(out_data_available), 32'd0);
        check("w2_done", 32'(done_pool), 32'd1);

        // Partial flush W4 max: 9,3,12 then drop; mid-stream config change ignored
        pool_window_size = 2'b10;
        send(32'h00000009, 4'hF);
        enable_pool      = 1'b0;
        pool_window_size = 2'b00;
        send(32'h00000003, 4'hF);
        check("pf_cfg_ignored", 32'(out_data_available), 32'd0);
        send(32'h0000000C, 4'hF);
        check("pf_quiet", 32'(out_data_available), 32'd0);
        idle();
        check("pf_avail", 32'(out_data_available), 32'd1);
        check("pf_data", out_data, 32'h0000000C);
        idle();
        check("pf_avail_off", 32'(out_data_available), 32'd0);
        check("pf_done", 32'(done_pool), 32'd1);

        // Mask of the final vector gates the output
        enable_pool      = 1'b1;
        pool_window_size = 2'b01;
        send(32'h7F7F7F7F, 4'hF);
        send(32'h7F7F7F7F, 4'b0101);
        check("mask_data", out_data, 32'h007F007F);
        idle();

        // Reserved encoding behaves as W4
        pool_window_size = 2'b11;
        send(32'h00000001, 4'hF);
        send(32'h00000004, 4'hF);
        check("rsv_not_w2", 32'(out_data_available), 32'd0);
        send(32'h00000003, 4'hF);
        send(32'h00000002, 4'hF);
        check("rsv_avail", 32'(out_data_available), 32'd1);
        check("rsv_data", out_data, 32'h00000004);
        idle();

        // Reset mid-window discards the partial window
        pool_window_size = 2'b10;
        send(32'h00000050, 4'hF);
        send(32'h00000060, 4'hF);
        resetn = 1'b0;
        #1;
        check("mr_data", out_data, 32'h0);
        check("mr_avail", 32'(out_data_available), 32'd0);
        check("mr_done", 32'(done_pool), 32'd0);
        in_data_available = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle();
        check("mr_no_pulse", 32'(out_data_available), 32'd0);
        pool_window_size = 2'b01;
        send(32'h00000001, 4'hF);
        check("mr_restart_quiet", 32'(out_data_available), 32'd0);
        send(32'h00000002, 4'hF);
        check("mr_restart_avail", 32'(out_data_available), 32'd1);
        check("mr_restart_data", out_data, 32'h00000002);
        idle();
        check("mr_restart_done", 32'(done_pool), 32'd1);

`ifdef POOL_AVG_EN
        // Average W4: lane0 10,20,30,41 -> 25; lane1 -1,-1,-1,-2 -> -2
        pool_select      = 1'b1;
        pool_window_size = 2'b10;
        send(32'h0000FF0A, 4'hF);
        send(32'h0000FF14, 4'hF);
        send(32'h0000FF1E, 4'hF);
        send(32'h0000FE29, 4'hF);
        check("avg_w4_data", out_data, 32'h0000FE19);
        idle();
        // Partial average divides by the full window: 7 >>> 1 = 3
        pool_window_size = 2'b01;
        send(32'h00000007, 4'hF);
        idle();
        check("avg_pf_data", out_data, 32'h00000003);
        idle();
        pool_select = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
